// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle: ID, pipeline-register and MDU handshake signals.
// master drives the ID/pipeline side, slave is the controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ID_RS_Address;
  logic [4:0]       ID_RT_Address;
  logic             ID_uses_rt;
  logic             ID_mdu_op;
  logic [8:0]       Ctrl_in;
  logic             branch_taken;
  logic             EX_MemRead;
  logic [4:0]       EX_RT_Address;
  logic [4:0]       EX_RS_Address;
  logic             MEM_RegWrite;
  logic [4:0]       MEM_dest;
  logic             WB_RegWrite;
  logic [4:0]       WB_dest;
  logic             mdu_done;
  logic [8:0]       Ctrl_out;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             mdu_start;
  logic             mdu_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ID_RS_Address, ID_RT_Address, ID_uses_rt, ID_mdu_op, Ctrl_in, branch_taken,
           EX_MemRead, EX_RT_Address, EX_RS_Address, MEM_RegWrite, MEM_dest,
           WB_RegWrite, WB_dest, mdu_done,
    input  Ctrl_out, PC_write, IF_ID_write, IF_ID_flush, ForwardA, ForwardB,
           mdu_start, mdu_err, stall_cnt
  );

  modport slave (
    input  ID_RS_Address, ID_RT_Address, ID_uses_rt, ID_mdu_op, Ctrl_in, branch_taken,
           EX_MemRead, EX_RT_Address, EX_RS_Address, MEM_RegWrite, MEM_dest,
           WB_RegWrite, WB_dest, mdu_done,
    output Ctrl_out, PC_write, IF_ID_write, IF_ID_flush, ForwardA, ForwardB,
           mdu_start, mdu_err, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush, EX forwarding selects,
// multi-cycle MDU sequencing with timeout and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int unsigned WaitW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;

  typedef enum logic [0:0] {StRun, StMduWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q;

  logic             load_use;
  logic             timeout;
  logic             pc_write;

  // Register 0 is hardwired, so a match on it never creates a dependency.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_we, input logic [4:0] mem_dst,
                                         input logic wb_we, input logic [4:0] wb_dst);
    if (mem_we && mem_dst != 5'd0 && mem_dst == src) return 2'b10;
    if (wb_we && wb_dst != 5'd0 && wb_dst == src)    return 2'b01;
    return 2'b00;
  endfunction

  assign load_use = bus.EX_MemRead && bus.EX_RT_Address != 5'd0 &&
                    (bus.EX_RT_Address == bus.ID_RS_Address ||
                     (bus.ID_uses_rt && bus.EX_RT_Address == bus.ID_RT_Address));
  assign timeout  = (wait_q == WaitW'(MDU_TIMEOUT - 1));

  // Output decode and next-state selection for the RUN/MDU_WAIT sequencer.
  always_comb begin
    pc_write         = 1'b1;
    bus.IF_ID_write  = 1'b1;
    bus.IF_ID_flush  = 1'b0;
    bus.Ctrl_out     = bus.Ctrl_in;
    bus.mdu_start    = 1'b0;
    bus.ForwardA     = fwd_sel(bus.EX_RS_Address, bus.MEM_RegWrite, bus.MEM_dest,
                               bus.WB_RegWrite, bus.WB_dest);
    bus.ForwardB     = fwd_sel(bus.EX_RT_Address, bus.MEM_RegWrite, bus.MEM_dest,
                               bus.WB_RegWrite, bus.WB_dest);
    state_d          = state_q;
    wait_d           = wait_q;
    err_d            = err_q;
    if (rst) begin
      bus.Ctrl_out = 9'd0;
      bus.ForwardA = 2'b00;
      bus.ForwardB = 2'b00;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            pc_write        = 1'b0;
            bus.IF_ID_write = 1'b0;
            bus.Ctrl_out    = 9'd0;
          end else if (bus.ID_mdu_op) begin
            // The mult/div itself proceeds into EX; everything behind it holds.
            pc_write        = 1'b0;
            bus.IF_ID_write = 1'b0;
            bus.mdu_start   = 1'b1;
            state_d         = StMduWait;
            wait_d          = '0;
          end else if (bus.branch_taken) begin
            bus.IF_ID_flush = 1'b1;
          end
        end
        StMduWait: begin
          pc_write        = 1'b0;
          bus.IF_ID_write = 1'b0;
          bus.Ctrl_out    = 9'd0;
          wait_d          = wait_q + 1'b1;
          // done wins over a coincident timeout.
          if (bus.mdu_done) begin
            state_d = StRun;
          end else if (timeout) begin
            err_d   = 1'b1;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Sequencer state, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (!pc_write && stall_q != {CNT_W{1'b1}}) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.PC_write  = pc_write;
  assign bus.mdu_err   = err_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; a narrow-counter copy checks saturation.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();
  hazard_stall_ctrl_if #(.CNT_W(3))  sat_bus ();

  hazard_stall_ctrl #(.MDU_TIMEOUT(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hazard_stall_ctrl #(.MDU_TIMEOUT(8), .CNT_W(3)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  assign sat_bus.ID_RS_Address = bus.ID_RS_Address;
  assign sat_bus.ID_RT_Address = bus.ID_RT_Address;
  assign sat_bus.ID_uses_rt    = bus.ID_uses_rt;
  assign sat_bus.ID_mdu_op     = bus.ID_mdu_op;
  assign sat_bus.Ctrl_in       = bus.Ctrl_in;
  assign sat_bus.branch_taken  = bus.branch_taken;
  assign sat_bus.EX_MemRead    = bus.EX_MemRead;
  assign sat_bus.EX_RT_Address = bus.EX_RT_Address;
  assign sat_bus.EX_RS_Address = bus.EX_RS_Address;
  assign sat_bus.MEM_RegWrite  = bus.MEM_RegWrite;
  assign sat_bus.MEM_dest      = bus.MEM_dest;
  assign sat_bus.WB_RegWrite   = bus.WB_RegWrite;
  assign sat_bus.WB_dest       = bus.WB_dest;
  assign sat_bus.mdu_done      = bus.mdu_done;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.ID_RS_Address  = 5'd0;
    bus.ID_RT_Address  = 5'd0;
    bus.ID_uses_rt     = 1'b0;
    bus.ID_mdu_op      = 1'b0;
    bus.Ctrl_in        = 9'h1C3;
    bus.branch_taken   = 1'b0;
    bus.EX_MemRead     = 1'b0;
    bus.EX_RT_Address  = 5'd0;
    bus.EX_RS_Address  = 5'd5;
    bus.MEM_RegWrite   = 1'b1;
    bus.MEM_dest       = 5'd5;
    bus.WB_RegWrite    = 1'b0;
    bus.WB_dest        = 5'd0;
    bus.mdu_done       = 1'b0;

    // Idle outputs while in reset, even with a forwarding match present.
    #2;
    check("rst_pc", bus.PC_write, 1);
    check("rst_ifid", bus.IF_ID_write, 1);
    check("rst_flush", bus.IF_ID_flush, 0);
    check("rst_ctrl", bus.Ctrl_out, 0);
    check("rst_start", bus.mdu_start, 0);
    check("rst_fwda", bus.ForwardA, 0);
    step();
    check("rst_cnt", bus.stall_cnt, 0);
    check("rst_err", bus.mdu_err, 0);
    rst            = 1'b0;
    bus.MEM_RegWrite = 1'b0;
    bus.MEM_dest     = 5'd0;

    // Load-use on rs: one bubble cycle.
    bus.EX_MemRead    = 1'b1;
    bus.EX_RT_Address = 5'd2;
    bus.ID_RS_Address = 5'd2;
    #1;
    check("lu_pc", bus.PC_write, 0);
    check("lu_ifid", bus.IF_ID_write, 0);
    check("lu_ctrl", bus.Ctrl_out, 0);
    step();
    check("lu_cnt", bus.stall_cnt, 1);
    bus.EX_MemRead = 1'b0;
    #1;
    check("lu_after_ctrl", bus.Ctrl_out, 9'h1C3);
    check("lu_after_pc", bus.PC_write, 1);

    // rt match only counts when ID actually reads rt.
    bus.EX_MemRead    = 1'b1;
    bus.ID_RS_Address = 5'd3;
    bus.ID_RT_Address = 5'd2;
    bus.ID_uses_rt    = 1'b0;
    #1;
    check("rt_unused_pc", bus.PC_write, 1);
    bus.ID_uses_rt = 1'b1;
    #1;
    check("rt_used_pc", bus.PC_write, 0);
    step();
    check("rt_cnt", bus.stall_cnt, 2);

    // Load into $0 never stalls.
    bus.EX_RT_Address = 5'd0;
    bus.ID_RS_Address = 5'd0;
    bus.ID_RT_Address = 5'd0;
    #1;
    check("r0_pc", bus.PC_write, 1);
    check("r0_ctrl", bus.Ctrl_out, 9'h1C3);
    step();
    check("r0_cnt", bus.stall_cnt, 2);

    // Branch during load-use: stall only; flush on the following cycle.
    bus.EX_RT_Address = 5'd4;
    bus.ID_RS_Address = 5'd4;
    bus.branch_taken  = 1'b1;
    #1;
    check("br_lu_flush", bus.IF_ID_flush, 0);
    check("br_lu_pc", bus.PC_write, 0);
    step();
    bus.EX_MemRead = 1'b0;
    #1;
    check("br_flush", bus.IF_ID_flush, 1);
    check("br_pc", bus.PC_write, 1);
    check("br_ctrl", bus.Ctrl_out, 9'h1C3);
    step();
    bus.branch_taken = 1'b0;
    check("br_cnt", bus.stall_cnt, 3);

    // Load-use outranks a mult/div in ID.
    bus.EX_MemRead = 1'b1;
    bus.ID_mdu_op  = 1'b1;
    #1;
    check("lu_mdu_start", bus.mdu_start, 0);
    check("lu_mdu_ctrl", bus.Ctrl_out, 0);
    step();
    bus.EX_MemRead = 1'b0;
    check("lu_mdu_cnt", bus.stall_cnt, 4);

    // MDU op with done 5 cycles after start.
    #1;
    check("mdu_start", bus.mdu_start, 1);
    check("mdu_ctrl1", bus.Ctrl_out, 9'h1C3);
    check("mdu_pc1", bus.PC_write, 0);
    step();
    bus.ID_mdu_op = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      bus.mdu_done     = (c == 6);
      bus.branch_taken = (c == 3);
      #1;
      check("mdu_wait_start", bus.mdu_start, 0);
      check("mdu_wait_ctrl", bus.Ctrl_out, 0);
      check("mdu_wait_pc", bus.PC_write, 0);
      check("mdu_wait_flush", bus.IF_ID_flush, 0);
      step();
    end
    bus.mdu_done     = 1'b0;
    bus.branch_taken = 1'b0;
    #1;
    check("mdu_run_pc", bus.PC_write, 1);
    check("mdu_run_ctrl", bus.Ctrl_out, 9'h1C3);
    check("mdu_cnt", bus.stall_cnt, 10);
    check("sat_cnt", sat_bus.stall_cnt, 7);
    check("mdu_err0", bus.mdu_err, 0);

    // done coinciding with timeout: treated as done.
    bus.ID_mdu_op = 1'b1;
    step();
    bus.ID_mdu_op = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.mdu_done = (c == 7);
      #1;
      check("edge_wait_pc", bus.PC_write, 0);
      step();
    end
    bus.mdu_done = 1'b0;
    #1;
    check("edge_err", bus.mdu_err, 0);
    check("edge_pc", bus.PC_write, 1);
    check("edge_cnt", bus.stall_cnt, 19);

    // Timeout: err after 8 waiting cycles, back to RUN, sticky.
    bus.ID_mdu_op = 1'b1;
    step();
    bus.ID_mdu_op = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("to_wait_err", bus.mdu_err, 0);
      check("to_wait_pc", bus.PC_write, 0);
      step();
    end
    check("to_err", bus.mdu_err, 1);
    check("to_pc", bus.PC_write, 1);
    check("to_cnt", bus.stall_cnt, 28);
    step();
    check("to_sticky", bus.mdu_err, 1);

    // Reset in the middle of MDU_WAIT.
    bus.ID_mdu_op = 1'b1;
    step();
    bus.ID_mdu_op = 1'b0;
    #1;
    check("rw_wait_pc", bus.PC_write, 0);
    rst = 1'b1;
    #1;
    check("rw_rst_pc", bus.PC_write, 1);
    check("rw_rst_ctrl", bus.Ctrl_out, 0);
    step();
    check("rw_cnt", bus.stall_cnt, 0);
    check("rw_err", bus.mdu_err, 0);
    rst = 1'b0;
    #1;
    check("rw_run_pc", bus.PC_write, 1);
    check("rw_run_start", bus.mdu_start, 0);
    check("rw_run_ctrl", bus.Ctrl_out, 9'h1C3);
    step();
    check("rw_run_pc2", bus.PC_write, 1);

    // Forwarding priority and $0 suppression.
    bus.MEM_RegWrite  = 1'b1;
    bus.MEM_dest      = 5'd5;
    bus.WB_RegWrite   = 1'b1;
    bus.WB_dest       = 5'd5;
    bus.EX_RS_Address = 5'd5;
    bus.EX_RT_Address = 5'd5;
    #1;
    check("fwd_a_mem", bus.ForwardA, 2'b10);
    check("fwd_b_mem", bus.ForwardB, 2'b10);
    bus.MEM_RegWrite = 1'b0;
    #1;
    check("fwd_a_wb", bus.ForwardA, 2'b01);
    check("fwd_b_wb", bus.ForwardB, 2'b01);
    bus.MEM_RegWrite = 1'b1;
    bus.MEM_dest     = 5'd0;
    bus.WB_dest      = 5'd0;
    bus.EX_RS_Address = 5'd0;
    bus.EX_RT_Address = 5'd0;
    #1;
    check("fwd_a_r0", bus.ForwardA, 2'b00);
    check("fwd_b_r0", bus.ForwardB, 2'b00);
    bus.MEM_dest      = 5'd5;
    bus.WB_dest       = 5'd7;
    bus.EX_RS_Address = 5'd5;
    bus.EX_RT_Address = 5'd7;
    #1;
    check("fwd_a_split", bus.ForwardA, 2'b10);
    check("fwd_b_split", bus.ForwardB, 2'b01);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
